load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter ADDR_W, default 32, memory address width; ADDR_W <= XLEN.
REQ-003 Parameter TIMEOUT, default 15, maximum cycles in WAIT before an access fault; must be >= 1.
REQ-004 Clock and reset: one clock, clk; reset is asynchronous and active-high, reset.
REQ-005 Ports, in order:
- clk  in  1  clock
- reset  in  1  async active-high reset
- op_valid  in  1  operation offered
- op_ready  out  1  operation accepted when high together with op_valid
- op  in  mem_op_t  memory operation
- base  in  XLEN  base address
- offset  in  XLEN  address offset
- wdata  in  XLEN  store data, right-justified
- mem_req  out  1  memory request
- mem_we  out  1  1 = store, 0 = load
- mem_addr  out  ADDR_W  lane-aligned address; low log2(XLEN/8) bits are zero
- mem_be  out  XLEN/8  byte enables
- mem_wdata  out  XLEN  lane-positioned store data
- mem_gnt  in  1  request granted
- mem_rvalid  in  1  read data valid
- mem_rdata  in  XLEN  read data
- wb_valid  out  1  load result valid, one-cycle pulse
- wb_data  out  XLEN  extended load result
- misaligned  out  1  misalignment fault, one-cycle pulse
- access_fault  out  1  timeout or illegal-op fault, one-cycle pulse
- busy  out  1  high in every state except IDLE

Function
REQ-006 FSM states are IDLE, REQ, WAIT and RESP; op_ready is 1 only in IDLE.
REQ-007 The accept cycle latches op, wdata and ea = (base + offset) mod 2^XLEN.
REQ-008 Access size: B = 1, H = 2, W = 4, D = 8 bytes; ea that is not a multiple of the size pulses misaligned on the next cycle, issues no memory request, and returns to IDLE.
REQ-009 LD, LWU and SD with XLEN = 32 pulse access_fault on the next cycle, issue no memory request, and return to IDLE.
REQ-010 NOP is accepted and produces no memory activity and no pulse.
REQ-011 In REQ, mem_req = 1 and mem_we, mem_addr, mem_be and mem_wdata are held stable until mem_gnt is sampled high.
REQ-012 Byte enables: mem_be has size-many ones starting at lane = ea[log2(XLEN/8)-1:0].
REQ-013 Store data: mem_wdata is wdata shifted left by 8 × lane; bytes outside the enabled lanes are 0.
REQ-014 A store whose grant is sampled returns to IDLE; op_ready is high on the following cycle.
REQ-015 A load whose grant is sampled moves to WAIT.
REQ-016 In WAIT, mem_rvalid = 1 moves to RESP, latching mem_rdata.
REQ-017 In RESP, the selected lanes are shifted down by 8 × lane; signed ops (LB, LH, LW) sign-extend and unsigned ops zero-extend to XLEN.
REQ-018 wb_data is registered, wb_valid pulses on the cycle after RESP, and the FSM returns to IDLE.
REQ-019 Minimum load latency: accept at cycle 0, mem_req at cycle 1 with grant, rvalid at cycle 2, wb_valid at cycle 4.
REQ-020 The WAIT counter resets on entry to WAIT; if TIMEOUT cycles pass without rvalid, access_fault pulses, the FSM returns to IDLE, and a later stray rvalid is ignored.
REQ-021 mem_gnt and mem_rvalid in the same cycle while in REQ: the grant is taken and the rvalid is ignored.
REQ-022 wb_data holds its last value between pulses.
REQ-023 Pulses never overlap: at most one of wb_valid, misaligned and access_fault is high in any cycle.

Reset
REQ-024 Reset is asynchronous: state goes to IDLE and all outputs go to 0, except op_ready, which goes to 1.
REQ-025 Reset mid-transaction abandons it without a pulse; mem_req drops to 0 immediately.

Structure
REQ-026 Package my_pkg holds mem_op_t (NOP, LB, LBU, LH, LHU, LW, LWU, LD, SB, SH, SW, SD) and lsu_state_t.
REQ-027 Lane alignment and sign extension live in a combinational sub-module, lsu_align, which is instantiated once.

Verification
REQ-028 Scenario: XLEN = 32, SB, base 0x100, offset 3, wdata 0xAB, gnt immediate -> mem_addr 0x100, mem_be 4'b1000, mem_wdata 0xAB000000.
REQ-029 Scenario: LH at ea 0x202, rdata 0x80010000 -> wb_data 0xFFFF8001; LHU at the same ea -> wb_data 0x00008001.
REQ-030 Scenario: LW at ea 0x102 -> misaligned pulses once, mem_req stays 0, and op_ready returns on the next cycle.
REQ-031 Scenario: XLEN = 64, LD at ea 0x8 with gnt delayed 3 cycles -> mem_req held for 4 cycles with stable signals and mem_be 8'hFF.
REQ-032 Scenario: LW with rvalid withheld -> access_fault after TIMEOUT = 15 WAIT cycles; a later rvalid produces no wb_valid.
REQ-033 Scenario: reset asserted while in WAIT -> IDLE immediately, no pulse, and op_ready = 1.

Source files
------------

// File: rtl/my_pkg.sv
// Shared types and decode helpers for the load/store unit.
package my_pkg;

    typedef enum logic [3:0] {
        NOP, LB, LBU, LH, LHU, LW, LWU, LD, SB, SH, SW, SD
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE, REQ, WAIT, RESP
    } lsu_state_t;

    // log2 of the access size in bytes (NOP reports byte size, never used)
    function automatic logic [1:0] size_log2(input mem_op_t op);
        case (op)
            LH, LHU, SH: size_log2 = 2'd1;
            LW, LWU, SW: size_log2 = 2'd2;
            LD, SD:      size_log2 = 2'd3;
            default:     size_log2 = 2'd0;
        endcase
    endfunction

    function automatic logic is_store(input mem_op_t op);
        is_store = (op == SB) || (op == SH) || (op == SW) || (op == SD);
    endfunction

    function automatic logic is_signed(input mem_op_t op);
        is_signed = (op == LB) || (op == LH) || (op == LW);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables, store-data placement, load extraction and extension.
module lsu_align
    import my_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NB     = XLEN / 8,
    parameter int LANE_W = $clog2(NB)
) (
    input  mem_op_t           op,
    input  logic [LANE_W-1:0] lane,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata,
    output logic [NB-1:0]     be,
    output logic [XLEN-1:0]   store_data,
    output logic [XLEN-1:0]   load_data
);

    logic [NB-1:0]   be_base;
    logic [XLEN-1:0] dmask;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] raw;
    logic            sign;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        be_base = NB'(8'h01);
        sign    = 1'b0;
        case (size_log2(op))
            2'd1:    be_base = NB'(8'h03);
            2'd2:    be_base = NB'(8'h0F);
            2'd3:    be_base = NB'(8'hFF);
            default: be_base = NB'(8'h01);
        endcase

        for (int i = 0; i < NB; i++) begin
            dmask[8*i +: 8] = {8{be_base[i]}};
        end

        be         = be_base << lane;
        store_data = (wdata & dmask) << {lane, 3'b000};

        shifted = rdata >> {lane, 3'b000};
        raw     = shifted & dmask;
        case (size_log2(op))
            2'd0:    sign = shifted[7];
            2'd1:    sign = shifted[15];
            2'd2:    sign = shifted[31];
            default: sign = 1'b0;
        endcase
        load_data = (is_signed(op) && sign) ? (raw | ~dmask) : raw;
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accept, fault checks, request/grant handshake, response and writeback.
module load_store_unit
    import my_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                op_valid,
    output logic                op_ready,
    input  mem_op_t             op,
    input  logic [XLEN-1:0]     base,
    input  logic [XLEN-1:0]     offset,
    input  logic [XLEN-1:0]     wdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN/8-1:0]   mem_be,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic                wb_valid,
    output logic [XLEN-1:0]     wb_data,
    output logic                misaligned,
    output logic                access_fault,
    output logic                busy
);

    localparam int NB     = XLEN / 8;
    localparam int LANE_W = $clog2(NB);
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    lsu_state_t        state, state_nxt;
    mem_op_t           op_q;
    logic [XLEN-1:0]   wdata_q;
    logic [ADDR_W-1:0] ea_q;
    logic [XLEN-1:0]   rdata_q;
    logic [CNT_W-1:0]  cnt;
    logic              mis_nxt, fault_nxt;

    logic [ADDR_W-1:0] ea_in;
    logic [2:0]        align_mask;
    logic              illegal_in, misalign_in;
    logic [NB-1:0]     be_al;
    logic [XLEN-1:0]   store_al, load_al;

    assign ea_in       = ADDR_W'(base + offset);
    assign align_mask  = 3'((4'b0001 << size_log2(op)) - 4'd1);
    assign misalign_in = |(ea_in[2:0] & align_mask);
    assign illegal_in  = (XLEN == 32) && ((op == LD) || (op == LWU) || (op == SD));

    lsu_align #(.XLEN(XLEN)) u_align (
        .op         (op_q),
        .lane       (ea_q[LANE_W-1:0]),
        .wdata      (wdata_q),
        .rdata      (rdata_q),
        .be         (be_al),
        .store_data (store_al),
        .load_data  (load_al)
    );

    // Request outputs are gated by state so they read zero outside REQ and drop the instant reset hits.
    assign op_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign mem_req   = (state == REQ);
    assign mem_we    = mem_req && is_store(op_q);
    assign mem_addr  = mem_req ? {ea_q[ADDR_W-1:LANE_W], LANE_W'(0)} : '0;
    assign mem_be    = mem_req ? be_al : '0;
    assign mem_wdata = mem_req ? store_al : '0;

    always_comb begin
        state_nxt = state;
        mis_nxt   = 1'b0;
        fault_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (op_valid && (op != NOP)) begin
                    // An illegal op outranks misalignment when both apply.
                    if (illegal_in)       fault_nxt = 1'b1;
                    else if (misalign_in) mis_nxt   = 1'b1;
                    else                  state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) state_nxt = is_store(op_q) ? IDLE : WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_nxt = RESP;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_nxt = IDLE;
                    fault_nxt = 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            op_q         <= NOP;
            wdata_q      <= '0;
            ea_q         <= '0;
            rdata_q      <= '0;
            cnt          <= '0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            misaligned   <= 1'b0;
            access_fault <= 1'b0;
        end else begin
            state        <= state_nxt;
            wb_valid     <= (state == RESP);
            misaligned   <= mis_nxt;
            access_fault <= fault_nxt;
            if (op_valid && (state == IDLE)) begin
                op_q    <= op;
                wdata_q <= wdata;
                ea_q    <= ea_in;
            end
            if (state == REQ)       cnt <= '0;
            else if (state == WAIT) cnt <= cnt + 1'b1;
            if ((state == WAIT) && mem_rvalid) rdata_q <= mem_rdata;
            if (state == RESP)                 wb_data <= load_al;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: a 32-bit and a 64-bit instance driven through shared stimulus against a spec-level model.
module tb_load_store_unit;
    import my_pkg::*;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;            // 1 selects the 64-bit instance
    logic        op_valid, mem_gnt, mem_rvalid;
    mem_op_t     op;
    logic [63:0] base, offset, wdata, mem_rdata;

    int tests = 0;
    int fails = 0;
    logic [63:0] last_wb32 = '0, last_wb64 = '0;

    always #5 clk = ~clk;

    logic        r32_ready, r32_req, r32_we, r32_wbv, r32_mis, r32_af, r32_busy;
    logic [31:0] r32_addr, r32_wd, r32_wb;
    logic [3:0]  r32_be;
    logic        r64_ready, r64_req, r64_we, r64_wbv, r64_mis, r64_af, r64_busy;
    logic [31:0] r64_addr;
    logic [63:0] r64_wd, r64_wb;
    logic [7:0]  r64_be;

    load_store_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TIMEOUT)) u32 (
        .clk(clk), .reset(reset), .op_valid(op_valid & ~sel), .op_ready(r32_ready), .op(op),
        .base(base[31:0]), .offset(offset[31:0]), .wdata(wdata[31:0]),
        .mem_req(r32_req), .mem_we(r32_we), .mem_addr(r32_addr), .mem_be(r32_be), .mem_wdata(r32_wd),
        .mem_gnt(mem_gnt & ~sel), .mem_rvalid(mem_rvalid & ~sel), .mem_rdata(mem_rdata[31:0]),
        .wb_valid(r32_wbv), .wb_data(r32_wb), .misaligned(r32_mis), .access_fault(r32_af), .busy(r32_busy)
    );

    load_store_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT(TIMEOUT)) u64 (
        .clk(clk), .reset(reset), .op_valid(op_valid & sel), .op_ready(r64_ready), .op(op),
        .base(base), .offset(offset), .wdata(wdata),
        .mem_req(r64_req), .mem_we(r64_we), .mem_addr(r64_addr), .mem_be(r64_be), .mem_wdata(r64_wd),
        .mem_gnt(mem_gnt & sel), .mem_rvalid(mem_rvalid & sel), .mem_rdata(mem_rdata),
        .wb_valid(r64_wbv), .wb_data(r64_wb), .misaligned(r64_mis), .access_fault(r64_af), .busy(r64_busy)
    );

    wire        o_ready = sel ? r64_ready : r32_ready;
    wire        o_req   = sel ? r64_req   : r32_req;
    wire        o_we    = sel ? r64_we    : r32_we;
    wire        o_wbv   = sel ? r64_wbv   : r32_wbv;
    wire        o_mis   = sel ? r64_mis   : r32_mis;
    wire        o_af    = sel ? r64_af    : r32_af;
    wire        o_busy  = sel ? r64_busy  : r32_busy;
    wire [31:0] o_addr  = sel ? r64_addr  : r32_addr;
    wire [7:0]  o_be    = sel ? r64_be    : {4'b0, r32_be};
    wire [63:0] o_wd    = sel ? r64_wd    : {32'b0, r32_wd};
    wire [63:0] o_wb    = sel ? r64_wb    : {32'b0, r32_wb};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // At most one completion pulse per cycle on either instance.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check("one_pulse32", 64'($countones({r32_wbv, r32_mis, r32_af}) <= 1), 64'd1);
            check("one_pulse64", 64'($countones({r64_wbv, r64_mis, r64_af}) <= 1), 64'd1);
        end
    end

    function automatic int size_of(input mem_op_t o);
        case (o)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, LWU, SW: return 4;
            LD, SD:      return 8;
            default:     return 0;
        endcase
    endfunction

    function automatic logic [63:0] bmask(input int n);
        return (n >= 8) ? '1 : ((64'h1 << (8 * n)) - 64'h1);
    endfunction

    task automatic run_op(input mem_op_t o, input logic [63:0] b, input logic [63:0] off,
                          input logic [63:0] wd, input logic [63:0] rd,
                          input int gd, input int rvd, input logic also_rv);
        int          xl   = sel ? 64 : 32;
        int          nb   = xl / 8;
        int          sz   = size_of(o);
        logic [63:0] xm   = (xl == 64) ? '1 : 64'hFFFF_FFFF;
        logic [63:0] ea   = (b + off) & xm;
        int          lane = int'(ea % 64'(nb));
        logic        ill  = (xl == 32) && (o inside {LD, LWU, SD});
        logic        mis  = (sz > 0) && (ea % 64'(sz) != 0);
        logic        st   = o inside {SB, SH, SW, SD};
        logic [63:0] e_addr = (ea - 64'(lane)) & 64'hFFFF_FFFF;
        logic [63:0] e_be   = 64'(((1 << sz) - 1) << lane);
        logic [63:0] e_wd   = ((wd & bmask(sz)) << (8 * lane)) & xm;
        logic [63:0] e_ld   = ((rd & xm) >> (8 * lane)) & bmask(sz);
        logic [63:0] hold   = sel ? last_wb64 : last_wb32;
        if ((o inside {LB, LH, LW}) && e_ld[8*sz-1]) e_ld = e_ld | ~bmask(sz);
        e_ld = e_ld & xm;

        op = o; base = b; offset = off; wdata = wd; op_valid = 1'b1;
        check("accept_ready", 64'(o_ready), 64'd1);
        @(negedge clk);
        op_valid = 1'b0;

        if (o == NOP) begin
            check("nop_req", 64'(o_req), 64'd0);
            check("nop_pulses", 64'({o_wbv, o_mis, o_af}), 64'd0);
            check("nop_ready", 64'(o_ready), 64'd1);
        end else if (ill || mis) begin
            check("fault_af", 64'(o_af), 64'(ill));
            check("fault_mis", 64'(o_mis), 64'(!ill));
            check("fault_req", 64'(o_req), 64'd0);
            check("fault_ready", 64'(o_ready), 64'd1);
            @(negedge clk);
            check("fault_once", 64'({o_mis, o_af}), 64'd0);
            check("fault_noreq", 64'(o_req), 64'd0);
        end else begin
            for (int d = 0; d <= gd; d++) begin
                check("req", 64'(o_req), 64'd1);
                check("req_we", 64'(o_we), 64'(st));
                check("req_addr", 64'(o_addr), e_addr);
                check("req_be", 64'(o_be), e_be);
                check("req_wdata", st ? o_wd : 64'd0, st ? e_wd : 64'd0);
                check("req_ready", 64'(o_ready), 64'd0);
                if (d == gd) begin
                    mem_gnt = 1'b1;
                    if (also_rv) begin mem_rvalid = 1'b1; mem_rdata = ~rd; end
                end
                @(negedge clk);
                mem_gnt = 1'b0; mem_rvalid = 1'b0;
            end
            if (st) begin
                check("st_ready", 64'(o_ready), 64'd1);
                check("st_req_drop", 64'(o_req), 64'd0);
            end else if (rvd >= TIMEOUT) begin
                for (int w = 0; w < TIMEOUT; w++) begin
                    check("wait_busy", 64'(o_busy), 64'd1);
                    check("wait_nofault", 64'({o_af, o_wbv}), 64'd0);
                    @(negedge clk);
                end
                check("timeout_af", 64'(o_af), 64'd1);
                check("timeout_ready", 64'(o_ready), 64'd1);
                mem_rvalid = 1'b1; mem_rdata = rd;
                @(negedge clk);
                mem_rvalid = 1'b0;
                check("stray_af_once", 64'(o_af), 64'd0);
                check("stray_ready", 64'(o_ready), 64'd1);
                @(negedge clk);
                check("stray_no_wb", 64'(o_wbv), 64'd0);
                check("stray_wb_hold", o_wb, hold);
            end else begin
                for (int w = 0; w <= rvd; w++) begin
                    check("wait_busy", 64'(o_busy), 64'd1);
                    check("wait_no_wb", 64'(o_wbv), 64'd0);
                    if (w == rvd) begin mem_rvalid = 1'b1; mem_rdata = rd; end
                    @(negedge clk);
                    mem_rvalid = 1'b0;
                end
                check("resp_no_wb", 64'(o_wbv), 64'd0);
                check("resp_wb_hold", o_wb, hold);
                @(negedge clk);
                check("wb_valid", 64'(o_wbv), 64'd1);
                check("wb_data", o_wb, e_ld);
                check("wb_ready", 64'(o_ready), 64'd1);
                if (sel) last_wb64 = e_ld; else last_wb32 = e_ld;
                @(negedge clk);
                check("wb_once", 64'(o_wbv), 64'd0);
                check("wb_hold", o_wb, e_ld);
            end
        end
    endtask

    initial begin
        reset = 1'b1; sel = 1'b0; op_valid = 1'b0; op = NOP;
        base = '0; offset = '0; wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        #2;
        check("rst_ready32", 64'(r32_ready), 64'd1);
        check("rst_ready64", 64'(r64_ready), 64'd1);
        check("rst_outs32", 64'({r32_req, r32_we, r32_wbv, r32_mis, r32_af, r32_busy}), 64'd0);
        check("rst_outs64", 64'({r64_req, r64_we, r64_wbv, r64_mis, r64_af, r64_busy}), 64'd0);
        check("rst_bus32", {r32_addr, r32_wd} | 64'(r32_be) | 64'(r32_wb), 64'd0);
        check("rst_bus64", r64_wd | r64_wb | 64'(r64_addr) | 64'(r64_be), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_op(SB, 64'h100, 64'd3, 64'hAB, 64'h0, 0, 0, 1'b0);
        run_op(LH, 64'h200, 64'd2, 64'h0, 64'h8001_0000, 0, 0, 1'b0);
        run_op(LHU, 64'h200, 64'd2, 64'h0, 64'h8001_0000, 0, 0, 1'b0);
        run_op(LW, 64'h100, 64'd2, 64'h0, 64'h0, 0, 0, 1'b0);
        run_op(LD, 64'h0, 64'h8, 64'h0, 64'h0, 0, 0, 1'b0);
        run_op(NOP, 64'h0, 64'h0, 64'h0, 64'h0, 0, 0, 1'b0);
        run_op(LW, 64'h300, 64'h0, 64'h0, 64'h1234_5678, 1, TIMEOUT, 1'b0);
        run_op(LB, 64'hFFFF_FFFF, 64'h4, 64'h0, 64'h0000_8000, 0, TIMEOUT - 1, 1'b1);

        // Reset while waiting for read data.
        op = LW; base = 64'h104; offset = '0; op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("pre_rst_busy", 64'(r32_busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_ready", 64'(r32_ready), 64'd1);
        check("mid_rst_outs", 64'({r32_req, r32_busy, r32_wbv, r32_mis, r32_af}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_quiet", 64'({r32_wbv, r32_mis, r32_af, r32_busy}), 64'd0);
        last_wb32 = '0; last_wb64 = '0;

        sel = 1'b1;
        run_op(LD, 64'h0, 64'h8, 64'h0, 64'hDEAD_BEEF_0123_4567, 3, 1, 1'b0);
        run_op(LWU, 64'h1000, 64'h4, 64'h0, 64'h8765_4321_0000_0000, 0, 0, 1'b0);
        run_op(LW, 64'h1000, 64'h4, 64'h0, 64'h8765_4321_0000_0000, 0, 0, 1'b0);
        run_op(SH, 64'h2000, 64'h6, 64'hFFFF_FFFF_FFFF_1234, 64'h0, 2, 0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            sel = (i >= 40);
            run_op(mem_op_t'(4'($urandom_range(0, 11))),
                   {$urandom, $urandom} & ~64'h7, 64'($urandom_range(0, 7)),
                   {$urandom, $urandom}, {$urandom, $urandom},
                   $urandom_range(0, 3),
                   ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, 4),
                   1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
